// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic arbiter slice: the log2 helper used for
// index widths and the controller state encoding.
package cordic_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after last_grant+1, wrapping, and reports it both one-hot and as an index.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    grant_onehot,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);

  logic [ID_W-1:0] cand;

  // Walk the candidates in priority order; the first hit locks the result.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    cand         = '0;
    for (int i = 0; i < N; i++) begin
      cand = ID_W'((int'(last_grant) + 1 + i) % N);
      if (!any && req[cand]) begin
        any                = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Time-shares one combinational cordic core between NUM_REQ requesters,
// holding operands for a multicycle settle window and returning tagged results.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter  int WIDTH         = 32,
  parameter  int NUM_REQ       = 4,
  parameter  int SETTLE_CYCLES = 3,
  localparam int ID_W          = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  input  logic [NUM_REQ*WIDTH-1:0] req_z,
  output logic [WIDTH-1:0]         core_x_0,
  output logic [WIDTH-1:0]         core_y_0,
  output logic [WIDTH-1:0]         core_z_0,
  input  logic [WIDTH-1:0]         core_x_n,
  input  logic [WIDTH-1:0]         core_y_n,
  input  logic [WIDTH-1:0]         core_z_n,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_x,
  output logic [WIDTH-1:0]         rsp_y,
  output logic [WIDTH-1:0]         rsp_z,
  output logic                     busy
);

  localparam int CNT_W = clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] core_x_q, core_x_d, core_y_q, core_y_d, core_z_q, core_z_d;
  logic [WIDTH-1:0] rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d, rsp_z_q, rsp_z_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d, last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant_onehot(grant_onehot),
    .grant_idx   (grant_idx),
    .any         (grant_any)
  );

  // A grant only exists for a valid requester, so a grant in IDLE is an accept.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    core_z_d     = core_z_q;
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
    rsp_z_d      = rsp_z_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant_onehot;
        if (grant_any) begin
          core_x_d     = req_x[int'(grant_idx)*WIDTH +: WIDTH];
          core_y_d     = req_y[int'(grant_idx)*WIDTH +: WIDTH];
          core_z_d     = req_z[int'(grant_idx)*WIDTH +: WIDTH];
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = CNT_LOAD;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_x_d = core_x_n;
          rsp_y_d = core_y_n;
          rsp_z_d = core_z_n;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      core_z_q     <= '0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      rsp_z_q      <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      core_z_q     <= core_z_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
      rsp_z_q      <= rsp_z_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign core_x_0  = core_x_q;
  assign core_y_0  = core_y_q;
  assign core_z_0  = core_z_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = (state_q == ST_RESPOND);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: stub cores (x+1, y+2, z+3), a response scoreboard,
// and scenario tasks for grant order, latency, backpressure and reset.
module tb_cordic_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  logic [NUM_REQ-1:0]       reqValid, reqReady;
  logic [WIDTH-1:0]         reqX[NUM_REQ], reqY[NUM_REQ], reqZ[NUM_REQ];
  logic [NUM_REQ*WIDTH-1:0] reqXBus, reqYBus, reqZBus;
  logic [WIDTH-1:0]         coreX0, coreY0, coreZ0, coreXn, coreYn, coreZn;
  logic                     rspValid, rspReady, busy;
  logic [ID_W-1:0]          rspId;
  logic [WIDTH-1:0]         rspX, rspY, rspZ;

  always_comb begin
    reqXBus = '0;
    reqYBus = '0;
    reqZBus = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      reqXBus[k*WIDTH +: WIDTH] = reqX[k];
      reqYBus[k*WIDTH +: WIDTH] = reqY[k];
      reqZBus[k*WIDTH +: WIDTH] = reqZ[k];
    end
  end

  assign coreXn = coreX0 + 32'd1;
  assign coreYn = coreY0 + 32'd2;
  assign coreZn = coreZ0 + 32'd3;

  cordic_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady),
    .req_x(reqXBus), .req_y(reqYBus), .req_z(reqZBus),
    .core_x_0(coreX0), .core_y_0(coreY0), .core_z_0(coreZ0),
    .core_x_n(coreXn), .core_y_n(coreYn), .core_z_n(coreZn),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
    .rsp_x(rspX), .rsp_y(rspY), .rsp_z(rspZ), .busy(busy)
  );

  // Latency sweep instances share requester-0-only stimulus.
  logic [NUM_REQ-1:0]       swValid, s1Ready, s5Ready;
  logic [WIDTH-1:0]         swX, swY, swZ;
  logic [NUM_REQ*WIDTH-1:0] swXBus, swYBus, swZBus;
  logic [WIDTH-1:0]         s1X0, s1Y0, s1Z0, s5X0, s5Y0, s5Z0;
  logic [WIDTH-1:0]         s1RspX, s1RspY, s1RspZ, s5RspX, s5RspY, s5RspZ;
  logic [ID_W-1:0]          s1Id, s5Id;
  logic                     s1Valid, s5Valid, s1Busy, s5Busy;

  assign swXBus = {{((NUM_REQ-1)*WIDTH){1'b0}}, swX};
  assign swYBus = {{((NUM_REQ-1)*WIDTH){1'b0}}, swY};
  assign swZBus = {{((NUM_REQ-1)*WIDTH){1'b0}}, swZ};

  cordic_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SETTLE_CYCLES(1)) dutS1 (
    .clk(clk), .rst(rst), .req_valid(swValid), .req_ready(s1Ready),
    .req_x(swXBus), .req_y(swYBus), .req_z(swZBus),
    .core_x_0(s1X0), .core_y_0(s1Y0), .core_z_0(s1Z0),
    .core_x_n(s1X0 + 32'd1), .core_y_n(s1Y0 + 32'd2), .core_z_n(s1Z0 + 32'd3),
    .rsp_valid(s1Valid), .rsp_ready(1'b1), .rsp_id(s1Id),
    .rsp_x(s1RspX), .rsp_y(s1RspY), .rsp_z(s1RspZ), .busy(s1Busy)
  );

  cordic_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .SETTLE_CYCLES(5)) dutS5 (
    .clk(clk), .rst(rst), .req_valid(swValid), .req_ready(s5Ready),
    .req_x(swXBus), .req_y(swYBus), .req_z(swZBus),
    .core_x_0(s5X0), .core_y_0(s5Y0), .core_z_0(s5Z0),
    .core_x_n(s5X0 + 32'd1), .core_y_n(s5Y0 + 32'd2), .core_z_n(s5Z0 + 32'd3),
    .rsp_valid(s5Valid), .rsp_ready(1'b1), .rsp_id(s5Id),
    .rsp_x(s5RspX), .rsp_y(s5RspY), .rsp_z(s5RspZ), .busy(s5Busy)
  );

  typedef struct {
    int         id;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } expRsp_t;

  expRsp_t expQ[$];
  expRsp_t monExp;
  int nCompared   = 0;
  int nMismatched = 0;

  task automatic pushExpected(input int id);
    expRsp_t e;
    e.id = id;
    e.x  = reqX[id] + 32'd1;
    e.y  = reqY[id] + 32'd2;
    e.z  = reqZ[id] + 32'd3;
    expQ.push_back(e);
  endtask

  // Scoreboard pop on every response handshake, plus the one-hot ready rule.
  always @(negedge clk) begin
    if (!rst) begin
      nCompared++;
      if (!$onehot0(reqReady)) begin
        nMismatched++;
        $display("[TB] FAIL onehot_ready: req_ready=%b required one-hot or zero", reqReady);
      end
      if (rspValid && rspReady) begin
        nCompared++;
        if (expQ.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL unexpected_rsp: got id=%0d x=%h required no response", rspId, rspX);
        end else begin
          monExp = expQ.pop_front();
          if (int'(rspId) !== monExp.id || rspX !== monExp.x || rspY !== monExp.y || rspZ !== monExp.z) begin
            nMismatched++;
            $display("[TB] FAIL rsp_data: got id=%0d x=%h y=%h z=%h required id=%0d x=%h y=%h z=%h",
                     rspId, rspX, rspY, rspZ, monExp.id, monExp.x, monExp.y, monExp.z);
          end
        end
      end
    end
  end

  task automatic applyReset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic waitAccept(input int budget, output int id, output int cyc, output bit ok);
    ok  = 1'b0;
    id  = -1;
    cyc = -1;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (|(reqValid & reqReady)) begin
        ok  = 1'b1;
        cyc = cycleCnt;
        for (int k = 0; k < NUM_REQ; k++) if (reqReady[k]) id = k;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drainQueue(input string tag);
    for (int n = 0; n < 60 && expQ.size() != 0; n++) begin
      @(negedge clk); #1;
    end
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain_%s: got %0d pending responses required 0", tag, expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_reset();
    applyReset();
    @(negedge clk);
    nCompared++;
    if ({busy, rspValid, reqReady} !== 6'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got busy=%b rsp_valid=%b req_ready=%b required 0", busy, rspValid, reqReady);
    end
    nCompared++;
    if ({coreX0, coreY0, coreZ0} !== 96'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_core: got %h %h %h required 0", coreX0, coreY0, coreZ0);
    end
    nCompared++;
    if ({rspX, rspY, rspZ, rspId} !== 98'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_rsp: got id=%0d %h %h %h required 0", rspId, rspX, rspY, rspZ);
    end
  endtask

  task automatic test_single();
    int id, a;
    bit ok;
    @(posedge clk); #1;
    reqX[0] = 32'h10; reqY[0] = 32'h20; reqZ[0] = 32'h30;
    pushExpected(0);
    reqValid = 4'b0001;
    waitAccept(20, id, a, ok);
    reqValid = 4'b0000;
    nCompared++;
    if (!ok || id != 0) begin
      nMismatched++;
      $display("[TB] FAIL single_accept: got ok=%0d id=%0d required ok=1 id=0", ok, id);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b1 || rspValid !== (c == 4)) begin
        nMismatched++;
        $display("[TB] FAIL single_timing: cycle A+%0d got busy=%b rsp_valid=%b required busy=1 rsp_valid=%b",
                 c, busy, rspValid, (c == 4));
      end
    end
    nCompared++;
    if (rspX !== 32'h11 || rspY !== 32'h22 || rspZ !== 32'h33 || rspId !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL single_data: got id=%0d %h %h %h required id=0 11 22 33", rspId, rspX, rspY, rspZ);
    end
    @(negedge clk);
    nCompared++;
    if (rspValid !== 1'b0 || busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL single_idle: got rsp_valid=%b busy=%b required 0 0", rspValid, busy);
    end
    drainQueue("single");
  endtask

  task automatic test_round_robin();
    int expIds[5] = '{0, 1, 2, 3, 0};
    int id, cyc, prev;
    bit ok;
    applyReset();
    for (int k = 0; k < NUM_REQ; k++) begin
      reqX[k] = 32'h1000 * (k + 1) + k;
      reqY[k] = 32'h2000 * (k + 1) + k;
      reqZ[k] = 32'hF000_0000 + k;
    end
    for (int n = 0; n < 5; n++) pushExpected(expIds[n]);
    reqValid = 4'b1111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      waitAccept(30, id, cyc, ok);
      nCompared++;
      if (!ok || id != expIds[n]) begin
        nMismatched++;
        $display("[TB] FAIL rr_grant%0d: got ok=%0d id=%0d required id=%0d", n, ok, id, expIds[n]);
      end
      if (n > 0) begin
        nCompared++;
        if (cyc - prev != 5) begin
          nMismatched++;
          $display("[TB] FAIL rr_spacing%0d: got %0d cycles required 5", n, cyc - prev);
        end
      end
      prev = cyc;
    end
    reqValid = 4'b0000;
    drainQueue("rr");
  endtask

  task automatic test_fairness();
    int expIds[4] = '{2, 3, 0, 2};
    int id, cyc;
    bit ok;
    applyReset();
    for (int k = 0; k < NUM_REQ; k++) begin
      reqX[k] = 32'hA0 + k;
      reqY[k] = 32'hB0 + k;
      reqZ[k] = 32'hC0 + k;
    end
    for (int n = 0; n < 4; n++) pushExpected(expIds[n]);
    reqValid = 4'b1100;
    for (int n = 0; n < 4; n++) begin
      waitAccept(30, id, cyc, ok);
      if (n == 0) reqValid = 4'b1101;
      nCompared++;
      if (!ok || id != expIds[n]) begin
        nMismatched++;
        $display("[TB] FAIL fair_grant%0d: got ok=%0d id=%0d required id=%0d", n, ok, id, expIds[n]);
      end
    end
    reqValid = 4'b0000;
    drainQueue("fair");
  endtask

  task automatic test_backpressure();
    int id, cyc;
    bit ok, seen;
    applyReset();
    rspReady = 1'b0;
    reqX[1] = 32'h1234_5678; reqY[1] = 32'h8765_4321; reqZ[1] = 32'h4000_0000;
    reqX[2] = 32'h2222_0000; reqY[2] = 32'h0000_2222; reqZ[2] = 32'h8000_0000;
    pushExpected(1);
    reqValid = 4'b0010;
    waitAccept(20, id, cyc, ok);
    reqValid = 4'b0000;
    nCompared++;
    if (!ok || id != 1) begin
      nMismatched++;
      $display("[TB] FAIL bp_accept: got ok=%0d id=%0d required id=1", ok, id);
    end
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = rspValid;
    end
    nCompared++;
    if (!seen) begin
      nMismatched++;
      $display("[TB] FAIL bp_rsp_timeout: got no rsp_valid required rsp_valid within 10 cycles");
    end
    reqValid = 4'b0100;
    pushExpected(2);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      nCompared++;
      if (rspValid !== 1'b1 || rspId !== 2'd1 || rspX !== 32'h1234_5679 || rspY !== 32'h8765_4323 ||
          rspZ !== 32'h4000_0003 || reqReady !== 4'b0 || busy !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d x=%h y=%h z=%h rdy=%b busy=%b required v=1 id=1 x=12345679 y=87654323 z=40000003 rdy=0000 busy=1",
                 n, rspValid, rspId, rspX, rspY, rspZ, reqReady, busy);
      end
    end
    @(posedge clk); #1 rspReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nCompared++;
    if (rspValid !== 1'b0 || busy !== 1'b0 || reqReady !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL bp_release: got rsp_valid=%b busy=%b req_ready=%b required 0 0 0100", rspValid, busy, reqReady);
    end
    @(posedge clk); #1 reqValid = 4'b0000;
    drainQueue("bp");
  endtask

  task automatic test_latency_sweep();
    int a, first1, first5;
    bit ok;
    @(posedge clk); #1;
    swX = 32'hA5A5_0001; swY = 32'h5A5A_0002; swZ = 32'hC000_0000;
    swValid = 4'b0001;
    ok = 1'b0;
    a  = -1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (s1Ready[0] && s5Ready[0]) begin
        ok = 1'b1;
        a  = cycleCnt;
      end
    end
    nCompared++;
    if (!ok) begin
      nMismatched++;
      $display("[TB] FAIL sweep_accept: got ready s1=%b s5=%b required both 1", s1Ready[0], s5Ready[0]);
    end
    @(posedge clk); #1 swValid = 4'b0000;
    first1 = -1;
    first5 = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (s1Valid && first1 < 0) first1 = cycleCnt;
      if (s5Valid && first5 < 0) first5 = cycleCnt;
      nCompared++;
      if (s1X0 !== swX || s1Y0 !== swY || s1Z0 !== swZ || s5X0 !== swX || s5Y0 !== swY || s5Z0 !== swZ) begin
        nMismatched++;
        $display("[TB] FAIL sweep_core_stable A+%0d: got s1 %h %h %h s5 %h %h %h required %h %h %h",
                 c, s1X0, s1Y0, s1Z0, s5X0, s5Y0, s5Z0, swX, swY, swZ);
      end
      nCompared++;
      if (s1Busy !== (c <= 2) || s5Busy !== (c <= 6)) begin
        nMismatched++;
        $display("[TB] FAIL sweep_busy A+%0d: got s1=%b s5=%b required s1=%b s5=%b", c, s1Busy, s5Busy, (c <= 2), (c <= 6));
      end
    end
    nCompared++;
    if (first1 != a + 2) begin
      nMismatched++;
      $display("[TB] FAIL sweep_lat1: got first rsp_valid at A+%0d required A+2", first1 - a);
    end
    nCompared++;
    if (first5 != a + 6) begin
      nMismatched++;
      $display("[TB] FAIL sweep_lat5: got first rsp_valid at A+%0d required A+6", first5 - a);
    end
    nCompared++;
    if (s1RspX !== 32'hA5A5_0002 || s1RspY !== 32'h5A5A_0004 || s5RspZ !== 32'hC000_0003 || s1Id !== 2'd0 || s5Id !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL sweep_data: got s1x=%h s1y=%h s5z=%h ids=%0d,%0d required a5a50002 5a5a0004 c0000003 0,0",
               s1RspX, s1RspY, s5RspZ, s1Id, s5Id);
    end
  endtask

  task automatic test_reset_midflight();
    int id, cyc;
    bit ok;
    applyReset();
    reqX[0] = 32'h0F0F_0000; reqY[0] = 32'h0000_0F0F; reqZ[0] = 32'h1111_1111;
    reqX[3] = 32'h3333_0003; reqY[3] = 32'h0003_3333; reqZ[3] = 32'h7FFF_FFFF;
    reqValid = 4'b1000;
    waitAccept(20, id, cyc, ok);
    nCompared++;
    if (!ok || id != 3) begin
      nMismatched++;
      $display("[TB] FAIL midrst_accept3: got ok=%0d id=%0d required id=3", ok, id);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pushExpected(3);
    @(negedge clk);
    nCompared++;
    if (rspValid !== 1'b0 || busy !== 1'b0 || coreX0 !== 32'b0 || reqReady !== 4'b1000) begin
      nMismatched++;
      $display("[TB] FAIL midrst_only3: got rsp_valid=%b busy=%b core_x=%h req_ready=%b required 0 0 0 1000",
               rspValid, busy, coreX0, reqReady);
    end
    @(posedge clk); #1 reqValid = 4'b0000;
    drainQueue("midrst3");

    reqValid = 4'b1000;
    waitAccept(20, id, cyc, ok);
    reqValid = 4'b1001;
    nCompared++;
    if (!ok || id != 3) begin
      nMismatched++;
      $display("[TB] FAIL midrst_accept3b: got ok=%0d id=%0d required id=3", ok, id);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pushExpected(0);
    @(negedge clk);
    nCompared++;
    if (rspValid !== 1'b0 || reqReady !== 4'b0001) begin
      nMismatched++;
      $display("[TB] FAIL midrst_pref0: got rsp_valid=%b req_ready=%b required 0 0001", rspValid, reqReady);
    end
    @(posedge clk); #1 reqValid = 4'b0000;
    drainQueue("midrst0");
  endtask

  initial begin
    reqValid = '0;
    rspReady = 1'b1;
    swValid  = '0;
    swX = '0; swY = '0; swZ = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      reqX[k] = '0; reqY[k] = '0; reqZ[k] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_latency_sweep();
    test_reset_midflight();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running required completion before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
